// File: rtl/vred_logic_sequencer_pkg.sv
// vred_pkg: shared opcode constants, FSM state encoding and identity helper
// for the vector logic reduction sequencer.
package vred_pkg;

    localparam logic [1:0] OP_ZERO = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Identity element of a logic reduction, expressed as its fill bit:
    // all-ones for and, all-zeros for or/xor (and for the zero opcode).
    function automatic logic identity_bit(input logic [1:0] opSel);
        return (opSel == OP_AND);
    endfunction

endpackage

// File: rtl/vred_logic_sequencer_if.sv
// Request/response bundle of the vector logic reduction sequencer.
// Optional in_mask is present only when VRED_LOGIC_MASK_EN is defined.
interface vred_logic_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_ELEMS   = 8,
    parameter int OPSEL_WIDTH = 2
);
    logic                              in_valid;
    logic                              in_ready;
    logic [MAX_ELEMS*DATA_WIDTH-1:0]   in_vec;
    logic [DATA_WIDTH-1:0]             in_scalar;
    logic [OPSEL_WIDTH-1:0]            in_opSel;
    logic [$clog2(MAX_ELEMS):0]        in_vl;
`ifdef VRED_LOGIC_MASK_EN
    logic [MAX_ELEMS-1:0]              in_mask;
`endif
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_WIDTH-1:0]             out_scalar;
    logic                              busy;

    modport master (
        output in_valid, in_vec, in_scalar, in_opSel, in_vl,
`ifdef VRED_LOGIC_MASK_EN
        output in_mask,
`endif
        output out_ready,
        input  in_ready, out_valid, out_scalar, busy
    );

    modport slave (
        input  in_valid, in_vec, in_scalar, in_opSel, in_vl,
`ifdef VRED_LOGIC_MASK_EN
        input  in_mask,
`endif
        input  out_ready,
        output in_ready, out_valid, out_scalar, busy
    );

endinterface

// File: rtl/vred_logic_sequencer_unit.sv
// vRedAndOrXor_unit_block: one-step and/or/xor combiner with a registered
// result. in_vec0 = {element, accumulator}; with in_en low the low half is
// simply captured, which the sequencer uses both to load and to hold.
module vRedAndOrXor_unit_block
    import vred_pkg::*;
#(
    parameter int REQ_DATA_WIDTH  = 32,
    parameter int RESP_DATA_WIDTH = 32,
    parameter int OPSEL_WIDTH     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_en,
    input  logic [OPSEL_WIDTH-1:0]      in_opSel,
    input  logic [2*REQ_DATA_WIDTH-1:0] in_vec0,
    output logic [RESP_DATA_WIDTH-1:0]  out_vec
);

    logic [REQ_DATA_WIDTH-1:0]  w_opAcc;
    logic [REQ_DATA_WIDTH-1:0]  w_opElem;
    logic [RESP_DATA_WIDTH-1:0] w_result;

    assign w_opAcc  = in_vec0[REQ_DATA_WIDTH-1:0];
    assign w_opElem = in_vec0[2*REQ_DATA_WIDTH-1:REQ_DATA_WIDTH];

    // Combine accumulator and element; the zero opcode forces a zero result.
    always_comb begin
        w_result = '0;
        case (in_opSel)
            OP_AND:  w_result = w_opAcc & w_opElem;
            OP_OR:   w_result = w_opAcc | w_opElem;
            OP_XOR:  w_result = w_opAcc ^ w_opElem;
            default: w_result = '0;
        endcase
    end

    // Result register: combine when enabled, otherwise capture the low half.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vec <= '0;
        end else if (in_en) begin
            out_vec <= w_result;
        end else begin
            out_vec <= w_opAcc;
        end
    end

endmodule

// File: rtl/vred_logic_sequencer.sv
// vred_logic_sequencer: sequential and/or/xor reduction of up to MAX_ELEMS
// elements into a scalar, one element per cycle.
// Optional feature: define VRED_LOGIC_MASK_EN to add a per-element mask.
module vred_logic_sequencer
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_ELEMS   = 8,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vred_logic_sequencer_if.slave  bus
);

    localparam int VL_W  = $clog2(MAX_ELEMS) + 1;
    localparam int IDX_W = $clog2(MAX_ELEMS);
    localparam logic [VL_W-1:0] MAX_VL = VL_W'(MAX_ELEMS);

    state_t                          r_state;
    state_t                          w_nextState;
    logic [MAX_ELEMS*DATA_WIDTH-1:0] r_vec;
    logic [OPSEL_WIDTH-1:0]          r_opSel;
    logic [VL_W-1:0]                 r_vl;
    logic [IDX_W-1:0]                r_idx;
    logic [VL_W-1:0]                 w_vlClamped;
    logic                            w_accept;
    logic                            w_lastElem;
    logic                            w_unitEn;
    logic [2*DATA_WIDTH-1:0]         w_unitVec;
    logic [DATA_WIDTH-1:0]           w_elem;
    logic [DATA_WIDTH-1:0]           w_elemEff;
    logic [DATA_WIDTH-1:0]           w_acc;

    assign w_accept    = bus.in_valid && (r_state == ST_IDLE);
    assign w_vlClamped = (bus.in_vl > MAX_VL) ? MAX_VL : bus.in_vl;
    assign w_lastElem  = ({1'b0, r_idx} == (r_vl - VL_W'(1)));
    assign w_elem      = r_vec[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef VRED_LOGIC_MASK_EN
    logic [MAX_ELEMS-1:0] r_mask;

    // Capture the element mask together with the other operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= bus.in_mask;
        end
    end

    assign w_elemEff = r_mask[r_idx] ? w_elem
                                     : {DATA_WIDTH{identity_bit(r_opSel[1:0])}};
`else
    assign w_elemEff = w_elem;
`endif

    // Operand registers load only on accept so they stay frozen during RUN/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_opSel <= '0;
            r_vl    <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_vec   <= bus.in_vec;
            r_opSel <= bus.in_opSel;
            r_vl    <= w_vlClamped;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: an empty request skips RUN and reports the scalar.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = (w_vlClamped != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_lastElem) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Drive the combiner: fold in RUN, load scalar on accept, hold otherwise.
    always_comb begin
        w_unitEn  = 1'b0;
        w_unitVec = {{DATA_WIDTH{1'b0}}, w_acc};
        if (r_state == ST_RUN) begin
            w_unitEn  = 1'b1;
            w_unitVec = {w_elemEff, w_acc};
        end else if (w_accept) begin
            w_unitVec = {{DATA_WIDTH{1'b0}}, bus.in_scalar};
        end
    end

    // Handshake outputs are pure state decodes; the result is the accumulator.
    always_comb begin
        bus.in_ready   = (r_state == ST_IDLE);
        bus.out_valid  = (r_state == ST_DONE);
        bus.busy       = (r_state != ST_IDLE);
        bus.out_scalar = w_acc;
    end

    vRedAndOrXor_unit_block #(
        .REQ_DATA_WIDTH  (DATA_WIDTH),
        .RESP_DATA_WIDTH (DATA_WIDTH),
        .OPSEL_WIDTH     (OPSEL_WIDTH)
    ) u_unit (
        .clk      (clk),
        .rst      (rst),
        .in_en    (w_unitEn),
        .in_opSel (r_opSel),
        .in_vec0  (w_unitVec),
        .out_vec  (w_acc)
    );

endmodule

// File: tb/tb_vred_logic_sequencer.sv
// Directed testbench for vred_logic_sequencer (default 32-bit, 8 elements).
// With VRED_LOGIC_MASK_EN defined the masked-reduction case is also run.
module tb_vred_logic_sequencer;

    localparam int DW = 32;
    localparam int ME = 8;
    localparam int OW = 2;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    vred_logic_sequencer_if #(.DATA_WIDTH(DW), .MAX_ELEMS(ME), .OPSEL_WIDTH(OW)) bus ();

    vred_logic_sequencer #(
        .DATA_WIDTH  (DW),
        .MAX_ELEMS   (ME),
        .OPSEL_WIDTH (OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef VRED_LOGIC_MASK_EN
    logic [ME-1:0] tbMask;
`endif

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [ME*DW-1:0] pack8(
        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
        input logic [DW-1:0] e3, input logic [DW-1:0] e4, input logic [DW-1:0] e5,
        input logic [DW-1:0] e6, input logic [DW-1:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present one request for one cycle (the accept edge).
    task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] scalar,
                                 input logic [3:0] vl, input logic [ME*DW-1:0] vec);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_opSel  = op;
        bus.in_scalar = scalar;
        bus.in_vl     = vl;
        bus.in_vec    = vec;
`ifdef VRED_LOGIC_MASK_EN
        bus.in_mask   = tbMask;
`endif
        tick();
        bus.in_valid  = 1'b0;
    endtask

    // Full request: accept, measure latency, optionally stall in DONE with
    // junk requests on the input side, then consume the result.
    task automatic runRequest(input string tag, input logic [1:0] op,
                              input logic [DW-1:0] scalar, input logic [3:0] vl,
                              input logic [ME*DW-1:0] vec, input logic [DW-1:0] expRes,
                              input int expLat, input int holdCycles, input bit junk);
        int lat;
        applyStimulus(op, scalar, vl, vec);
        if (junk) begin
            bus.in_valid  = 1'b1;
            bus.in_opSel  = 2'b11;
            bus.in_scalar = 32'hDEADBEEF;
            bus.in_vl     = 4'd5;
            bus.in_vec    = {8{32'h5A5A1234}};
        end
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "_result"}, 64'(bus.out_scalar), 64'(expRes));
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput({tag, "_holdScalar"}, 64'(bus.out_scalar), 64'(expRes));
            checkOutput({tag, "_holdInReady"}, 64'(bus.in_ready), 64'd0);
            checkOutput({tag, "_holdValid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_inReadyAfter"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_validAfter"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Directed sequence.
    initial begin
        int seen;
        assertCount   = 0;
        failCount     = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opSel  = '0;
        bus.in_scalar = '0;
        bus.in_vl     = '0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
`ifdef VRED_LOGIC_MASK_EN
        tbMask        = '1;
        bus.in_mask   = '1;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst_inReady", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_outValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_outScalar", 64'(bus.out_scalar), 64'd0);

        $display("[TB] basic reductions");
        runRequest("xor4", 2'b11, 32'h0, 4'd4, pack8(32'h1, 32'h2, 32'h4, 32'h8, 0, 0, 0, 0),
                   32'hF, 5, 0, 0);
        runRequest("and3", 2'b01, 32'hFFFFFFFF, 4'd3,
                   pack8(32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFF0000, 0, 0, 0, 0, 0),
                   32'hF0000000, 4, 0, 0);
        runRequest("or3", 2'b10, 32'h0, 4'd3,
                   pack8(32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFF0000, 0, 0, 0, 0, 0),
                   32'hFFFFFFF0, 4, 0, 0);
        runRequest("zeroOp", 2'b00, 32'h1234, 4'd3,
                   pack8(32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0), 32'h0, 4, 0, 0);

        $display("[TB] boundary vl");
        runRequest("vl0", 2'b00, 32'h1234, 4'd0, pack8(32'hFF, 32'hFF, 0, 0, 0, 0, 0, 0),
                   32'h1234, 1, 0, 0);
        runRequest("vl0xor", 2'b11, 32'hABCD, 4'd0, pack8(32'hFF, 0, 0, 0, 0, 0, 0, 0),
                   32'hABCD, 1, 0, 0);
        runRequest("vl12", 2'b11, 32'h100, 4'd12,
                   pack8(32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80),
                   32'h1FF, 9, 0, 0);

        $display("[TB] stall in DONE with ignored inputs");
        runRequest("hold", 2'b11, 32'h0, 4'd4, pack8(32'h1, 32'h2, 32'h4, 32'h8, 0, 0, 0, 0),
                   32'hF, 5, 6, 1);

        $display("[TB] back-to-back");
        runRequest("b2bA", 2'b10, 32'h1, 4'd2, pack8(32'h10, 32'h100, 0, 0, 0, 0, 0, 0),
                   32'h111, 3, 0, 0);
        runRequest("b2bB", 2'b11, 32'hFFFF, 4'd2, pack8(32'hFF, 32'hF00F, 0, 0, 0, 0, 0, 0),
                   32'h0F0F, 3, 0, 0);

        $display("[TB] reset during RUN");
        applyStimulus(2'b11, 32'h77, 4'd8, pack8(1, 2, 3, 4, 5, 6, 7, 8));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst_inReady", 64'(bus.in_ready), 64'd1);
        checkOutput("midRst_outValid", 64'(bus.out_valid), 64'd0);
        checkOutput("midRst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midRst_outScalar", 64'(bus.out_scalar), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checkOutput("midRst_noResult", 64'(seen), 64'd0);
        runRequest("postRst", 2'b01, 32'hFFFFFFFF, 4'd2,
                   pack8(32'h0F0F0F0F, 32'h00FF00FF, 0, 0, 0, 0, 0, 0),
                   32'h000F000F, 3, 0, 0);

`ifdef VRED_LOGIC_MASK_EN
        $display("[TB] masked reduction");
        tbMask = 8'b0000_1110;
        runRequest("maskAnd", 2'b01, 32'hFFFFFFFF, 4'd4,
                   pack8(32'h0, 32'hFF, 32'hFF, 32'hFF, 0, 0, 0, 0), 32'hFF, 5, 0, 0);
        tbMask = 8'b0000_0101;
        runRequest("maskXor", 2'b11, 32'h0, 4'd4,
                   pack8(32'h1, 32'h2, 32'h4, 32'h8, 0, 0, 0, 0), 32'h5, 5, 0, 0);
        tbMask = '1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vred_logic_sequencer.md
VRED_LOGIC_SEQUENCER -- requirements
Module: vred_logic_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, element and scalar width in bits.
REQ-002 Parameter MAX_ELEMS, default 8, maximum elements per reduction; power of two, at least 2.
REQ-003 Parameter OPSEL_WIDTH, default 2, opcode width: 01=and, 10=or, 11=xor, 00=zero result.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 in_vec  input  MAX_ELEMS*DATA_WIDTH  source elements; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_scalar  input  DATA_WIDTH  initial accumulator value (vs1[0]).
REQ-010 in_opSel  input  OPSEL_WIDTH  reduction opcode.
REQ-011 in_vl  input  $clog2(MAX_ELEMS)+1  active element count.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 out_scalar  output  DATA_WIDTH  reduction result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
- in_ready = (state == IDLE).
- out_valid = (state == DONE).
REQ-017 On accept, the block SHALL register in_vec and in_opSel, load the accumulator with in_scalar, and clamp vl to MAX_ELEMS when in_vl > MAX_ELEMS.
- Element index is cleared to 0.
- Next state is RUN if vl > 0, otherwise DONE.
REQ-018 In RUN, each cycle SHALL combine acc with element[idx] using the registered opcode and increment idx.
- The cycle with idx == vl-1 moves to DONE.
REQ-019 Result SHALL equal scalar op e0 op ... op e(vl-1).
- Opcode 00 SHALL yield 0 when vl > 0.
- vl == 0 SHALL yield in_scalar for every opcode.
REQ-020 Latency: an accept in cycle T SHALL give out_valid in cycle T+vl+1.
REQ-021 In DONE, out_scalar and out_valid SHALL hold stable until out_ready.
- On the handshake, the state returns to IDLE.
- in_ready rises the following cycle; there is no same-cycle turnaround.
REQ-022 The accumulator SHALL be held unchanged in IDLE and DONE, and out_scalar SHALL always equal the accumulator.
REQ-023 Inputs presented while in_ready is low SHALL be ignored.
- Registered operands SHALL NOT change during RUN or DONE.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL enter IDLE regardless of state, including in the middle of RUN or DONE.
- Outputs: out_valid=0, out_scalar=0, busy=0, in_ready=1 in the cycle after reset.
REQ-025 An in-flight reduction SHALL be discarded with no result produced.

Configuration
REQ-026 Macro VRED_LOGIC_MASK_EN, when defined, SHALL add input in_mask, MAX_ELEMS wide.
- in_mask is registered on accept.
- Element i with mask bit 0 is replaced by the identity: all-ones for and, 0 for or/xor.
- Latency is unchanged (T+vl+1).
REQ-027 When VRED_LOGIC_MASK_EN is undefined, in_mask SHALL be absent and all elements below vl SHALL be active.

Structure
REQ-028 A shared package vred_pkg SHALL hold:
- opcode constants OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11;
- FSM state encodings;
- the identity-value function.
REQ-029 The block SHALL instantiate the existing vRedAndOrXor_unit_block as its single sub-module.
- Its registered output is the accumulator.
- in_vec0 = {element, acc} with in_en=1 in RUN.
- in_vec0 = {0, in_scalar} with in_en=0 on accept (load).
- in_vec0 = {0, acc} with in_en=0 in IDLE/DONE (hold).
- The requirement is width-consistent with the sub-module's RESP_DATA_WIDTH = REQ_DATA_WIDTH = DATA_WIDTH.

Verification
REQ-030 xor, scalar=0x0, vl=4, elems 0x1,0x2,0x4,0x8 -> out_scalar=0xF, out_valid exactly 5 cycles after accept.
REQ-031 and, scalar=0xFFFFFFFF, vl=3, elems 0xF0F0F0F0,0xFF00FF00,0xFFFF0000 -> 0xF0000000; or with same operands and scalar=0 -> 0xFFFFFFF0.
REQ-032 vl=0, scalar=0x1234, opcode 00 -> 0x1234 one cycle after accept; vl=12 with MAX_ELEMS=8 -> clamped to 8 elements, latency 9.
REQ-033 Hold out_ready low 6 cycles in DONE -> out_scalar stable and in_ready low throughout; in_ready high the cycle after the handshake; back-to-back requests both correct.
REQ-034 Assert rst in the 2nd RUN cycle of a vl=8 request -> next cycle IDLE, out_scalar=0, no out_valid; the next request's result is unaffected.
REQ-035 With VRED_LOGIC_MASK_EN: and, scalar=0xFFFFFFFF, elems 0x0,0xFF,0xFF,0xFF, mask=4'b1110, vl=4 -> 0xFF.
